// File: rtl/imem_responder_pkg.sv
// rtl/imem_responder_pkg.sv - shared FSM encodings and constants for the instruction-memory responder
package imem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } imem_state_e;

  localparam logic [31:0] INST_EBREAK       = 32'h0010_0073;
  localparam logic [31:0] IMEM_BASE_DEFAULT = 32'h8000_0000;

endpackage

// File: rtl/imem_responder_array.sv
// rtl/imem_responder_array.sv - 2^ADDR_W x 32 register array, one sync write port, one comb read port
module imem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [2**ADDR_W];

  // Program image survives reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - fetch responder: request FSM, latency counter, range check (IMEM_ALIGN_CHECK_EN adds alignment fault)
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter int          ADDR_W  = 10,
  parameter logic [31:0] BASE    = IMEM_BASE_DEFAULT,
  parameter int          LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_inst,
  output logic              rsp_err,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  imem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] rsp_inst_q, rsp_inst_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] rd_addr;
  logic [31:0] off;
  logic [31:0] arr_rdata;
  logic        fault;
  logic [31:0] fetch_inst;

  // With LATENCY==1 the response is formed on the accept edge, so look at the live request.
  assign rd_addr = (state_q == ST_IDLE) ? req_addr : addr_q;
  assign off     = rd_addr - BASE;

`ifdef IMEM_ALIGN_CHECK_EN
  assign fault = (|off[31:ADDR_W+2]) | (|rd_addr[1:0]);
  logic unused_off_lo;
  assign unused_off_lo = ^off[1:0];
`else
  assign fault = |off[31:ADDR_W+2];
  logic unused_addr_lo;
  assign unused_addr_lo = ^{off[1:0], rd_addr[1:0]};
`endif

  assign fetch_inst = fault ? INST_EBREAK : arr_rdata;

  imem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk   (clk),
    .we    (load_en),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (off[ADDR_W+1:2]),
    .rdata (arr_rdata)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    rsp_inst_d = rsp_inst_q;
    rsp_err_d  = rsp_err_q;
    req_ready  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d = req_addr;
          cnt_d  = CNT_INIT;
          if (LATENCY == 1) begin
            state_d    = ST_RESP;
            rsp_inst_d = fetch_inst;
            rsp_err_d  = fault;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = ST_RESP;
          rsp_inst_d = fetch_inst;
          rsp_err_d  = fault;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 32'd0;
      rsp_inst_q <= 32'd0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      rsp_inst_q <= rsp_inst_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_inst  = rsp_inst_q;
  assign rsp_err   = rsp_err_q;

endmodule
